// File: rtl/load_store_unit.sv
// Load/store unit between the multicycle datapath and a 64-bit doubleword memory.
// Optional LSU_PERF_CNT_EN adds load/store/fault completion counters.
module load_store_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [63:0] rdata,
  output logic [63:0] mem_raddress,
  output logic [63:0] mem_waddress,
  output logic [63:0] mem_datain,
  input  logic [63:0] mem_dataout,
  output logic        mem_wr
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] fault_count
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  localparam int CW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  typedef struct packed {
    logic        isStore;
    logic [2:0]  funct3;
    logic [2:0]  off;
    logic [63:0] wdata;
  } lsuReq_t;

  logic [1:0]    state;
  lsuReq_t       cur;
  logic          faultQ;
  logic [CW-1:0] cnt;
  logic          misAligned, reqFault, rdDone;
  logic [7:0]    sizeMask, laneMask;
  logic [63:0]   wShift, merged, lane, loadVal, alignedAddr;

  assign alignedAddr = {addr[63:3], 3'b000};
  assign rdDone      = (state == RD_WAIT) && (cnt == CW'(MEM_RD_LAT - 1));

  always_comb begin
    misAligned = 1'b0;
    case (funct3[1:0])
      2'd0:    misAligned = 1'b0;
      2'd1:    misAligned = addr[0];
      2'd2:    misAligned = |addr[1:0];
      default: misAligned = |addr[2:0];
    endcase
    reqFault = misAligned | (is_store ? funct3[2] : (funct3 == 3'b111));
  end

  // Byte-lane merge for sub-doubleword stores: new bytes land at off..off+size-1.
  always_comb begin
    sizeMask = 8'hFF;
    case (cur.funct3[1:0])
      2'd0:    sizeMask = 8'h01;
      2'd1:    sizeMask = 8'h03;
      2'd2:    sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
  end
  assign laneMask = sizeMask << cur.off;
  assign wShift   = cur.wdata << {cur.off, 3'b000};

  for (genvar i = 0; i < 8; i++) begin : gLane
    assign merged[8*i +: 8] = laneMask[i] ? wShift[8*i +: 8] : mem_dataout[8*i +: 8];
  end

  assign lane = mem_dataout >> {cur.off, 3'b000};
  always_comb begin
    loadVal = lane;
    case (cur.funct3)
      3'b000:  loadVal = {{56{lane[7]}},  lane[7:0]};
      3'b001:  loadVal = {{48{lane[15]}}, lane[15:0]};
      3'b010:  loadVal = {{32{lane[31]}}, lane[31:0]};
      3'b100:  loadVal = {56'd0, lane[7:0]};
      3'b101:  loadVal = {48'd0, lane[15:0]};
      3'b110:  loadVal = {32'd0, lane[31:0]};
      default: loadVal = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cur          <= '0;
      faultQ       <= 1'b0;
      cnt          <= '0;
      rdata        <= '0;
      mem_raddress <= '0;
      mem_waddress <= '0;
      mem_datain   <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cur.isStore <= is_store;
          cur.funct3  <= funct3;
          cur.off     <= addr[2:0];
          cur.wdata   <= wdata;
          faultQ      <= reqFault;
          cnt         <= '0;
          // Faulting requests never touch the memory address bus.
          if (reqFault) state <= DONE;
          else begin
            mem_raddress <= alignedAddr;
            mem_waddress <= alignedAddr;
            if (is_store && funct3 == 3'b011) begin
              mem_datain <= wdata;
              state      <= WRITE;
            end else state <= RD_WAIT;
          end
        end
        RD_WAIT: if (rdDone) begin
          if (cur.isStore) begin
            mem_datain <= merged;
            state      <= WRITE;
          end else begin
            rdata <= loadVal;
            state <= DONE;
          end
        end else cnt <= cnt + 1'b1;
        WRITE:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign mem_wr = (state == WRITE);
  assign fault  = done & faultQ;

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
      fault_count <= '0;
    end else if (done) begin
      if (faultQ)           fault_count <= fault_count + 1'b1;
      else if (cur.isStore) store_count <= store_count + 1'b1;
      else                  load_count  <= load_count + 1'b1;
    end
  end
`endif

endmodule
